// File: rtl/lc3_fetch_pkg.sv
// Shared types for the LC3 instruction-fetch queue.
//   fetch_entry_t : one buffered fetch {instr, npc}
//   fetch_state_t : fetch request FSM states
//   LC3_RESET_PC  : architectural reset PC
//   pc_inc()      : 16-bit modulo PC increment
package lc3_fetch_pkg;

    localparam int unsigned XLEN = 16;

    localparam logic [XLEN-1:0] LC3_RESET_PC = 16'h3000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] npc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Wraps FFFF -> 0000.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
        return a + XLEN'(1);
    endfunction

endpackage

// File: rtl/lc3_fetch_fifo.sv
// Small circular FIFO of fetch entries feeding decode.
// Ports:
//   clock, reset : clock, async active-high reset
//   push, wdata  : enqueue one entry
//   pop          : dequeue the head entry
//   flush        : empty the FIFO; wins over push and pop
//   head         : entry at the read pointer, read straight from storage
//   count        : number of valid entries (0..DEPTH)
module lc3_fetch_fifo
    import lc3_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/lc3_fetch_queue.sv
// LC3 instruction-fetch stage: owns the PC, issues variable-latency
// imem reads over req/ack, buffers {instr, npc} for decode, and
// flushes on an execute redirect.
// Optional feature macro: LC3_FETCH_BYPASS_EN (zero-latency forward of
// imem data to decode when the FIFO is empty and decode is ready).
// Ports:
//   clock, reset         : clock, async active-high reset
//   br_taken, taddr      : one-cycle redirect and its target
//   imem_req, imem_addr  : fetch request, address held until ack
//   imem_ack, imem_dout  : response strobe and instruction
//   dec_valid/instr/npc  : FIFO head presented to decode
//   dec_ready            : decode accepts the head
//   pc                   : address of the next fetch
//   fill_level           : FIFO occupancy
module lc3_fetch_queue
    import lc3_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = LC3_RESET_PC
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    br_taken,
    input  logic [15:0]             taddr,
    output logic                    imem_req,
    output logic [15:0]             imem_addr,
    input  logic                    imem_ack,
    input  logic [15:0]             imem_dout,
    output logic                    dec_valid,
    output logic [15:0]             dec_instr,
    output logic [15:0]             dec_npc,
    input  logic                    dec_ready,
    output logic [15:0]             pc,
    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    fetch_state_t   state;
    fetch_state_t   state_d;
    logic [15:0]    pc_d;
    logic [15:0]    addr_d;
    logic           req_d;

    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   wdata;

    logic           ack_live;
    logic           accept;
    logic           bypass;
    logic           push;
    logic           fifo_pop;
    logic [CW:0]    count_after;
    logic           room;

    // An ack only belongs to us while a live request is outstanding.
    assign ack_live = imem_ack && (state == REQ);
    assign accept   = ack_live && !br_taken;
    assign push     = accept && !bypass;
    assign fifo_pop = (count != '0) && dec_ready;
    assign wdata    = '{instr: imem_dout, npc: pc_inc(imem_addr)};

    // Occupancy after this cycle's push/pop decides whether to keep fetching.
    assign count_after = CW1'(count) + CW1'(push) - CW1'(fifo_pop);
    assign room        = count_after < CW1'(DEPTH);

`ifdef LC3_FETCH_BYPASS_EN
    assign bypass    = (count == '0) && accept && dec_ready;
    assign dec_valid = (count != '0) || bypass;
    assign dec_instr = bypass ? imem_dout : head.instr;
    assign dec_npc   = bypass ? pc_inc(imem_addr) : head.npc;
`else
    assign bypass    = 1'b0;
    assign dec_valid = (count != '0);
    assign dec_instr = head.instr;
    assign dec_npc   = head.npc;
`endif

    assign fill_level = count;

    lc3_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (fifo_pop),
        .flush (br_taken),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    // State register plus the registered request/PC outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!br_taken && room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (br_taken) begin
                    // Same-cycle ack is simply dropped; otherwise wait it out.
                    state_d = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    state_d = room ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next PC, request and address.
    always_comb begin
        pc_d   = pc;
        req_d  = (state_d != IDLE);
        addr_d = imem_addr;

        if (br_taken) begin
            pc_d = taddr;
        end else if (accept) begin
            pc_d = pc_inc(pc);
        end

        // Address only moves when a fresh request is launched.
        if ((state_d == REQ) && ((state == IDLE) || ack_live)) begin
            addr_d = pc_d;
        end
    end

endmodule

// File: tb/tb_lc3_fetch_queue.sv
// Scoreboard bench for lc3_fetch_queue: an imem model answers requests,
// accepted fetches are queued as expected decode entries and compared
// when decode pops them.
module tb_lc3_fetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h3000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         br_taken;
    logic [15:0]  taddr;
    logic         imem_req;
    logic [15:0]  imem_addr;
    logic         imem_ack;
    logic [15:0]  imem_dout;
    logic         dec_valid;
    logic [15:0]  dec_instr;
    logic [15:0]  dec_npc;
    logic         dec_ready;
    logic [15:0]  pc;
    logic [$clog2(DEPTH):0] fill_level;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_addr;
    logic        dead;
    int          n_vec = 0;
    int          n_err = 0;
    int          acks_taken = 0;

    always #5 clock = ~clock;

    lc3_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .br_taken   (br_taken),
        .taddr      (taddr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_dout  (imem_dout),
        .dec_valid  (dec_valid),
        .dec_instr  (dec_instr),
        .dec_npc    (dec_npc),
        .dec_ready  (dec_ready),
        .pc         (pc),
        .fill_level (fill_level)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive after the edge, check and update model at negedge.
    task automatic cyc(input logic ack, input logic br, input logic [15:0] ta, input logic rdy);
        logic        live;
        logic        exp_valid;
        logic [15:0] nxt;
        exp_t        e;
        @(posedge clock);
        #1;
        imem_ack  = ack && imem_req;
        imem_dout = mem_word(imem_addr);
        br_taken  = br;
        taddr     = ta;
        dec_ready = rdy;
        @(negedge clock);
        live      = imem_ack && !dead && !br;
        exp_valid = (sb.size() != 0);
`ifdef LC3_FETCH_BYPASS_EN
        if ((sb.size() == 0) && live && rdy) exp_valid = 1'b1;
`endif
        chk("dec_valid", dec_valid, exp_valid);
        chk("fill_level", fill_level, sb.size());
        chk("pc", pc, exp_addr);
        if (imem_req && !dead) chk("imem_addr", imem_addr, exp_addr);
        if (live) begin
            nxt     = exp_addr + 16'd1;
            e.instr = mem_word(exp_addr);
            e.npc   = nxt;
            sb.push_back(e);
            exp_addr = nxt;
            acks_taken++;
        end
        if (dec_valid && rdy) begin
            if (sb.size() == 0) begin
                chk("pop_empty", dec_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("dec_instr", dec_instr, e.instr);
                chk("dec_npc", dec_npc, e.npc);
            end
        end
        if (br) begin
            sb.delete();
            exp_addr = ta;
        end
        dead = imem_ack ? 1'b0 : (dead || (br && imem_req));
    endtask

    // Asynchronous reset mid-cycle, with a stray ack right after release.
    task automatic do_reset();
        @(posedge clock);
        #2;
        reset     = 1'b1;
        imem_ack  = 1'b0;
        br_taken  = 1'b0;
        dec_ready = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_instr", dec_instr, 16'h0000);
        chk("rst_npc", dec_npc, 16'h0000);
        chk("rst_fill", fill_level, 0);
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        imem_ack  = 1'b1;
        imem_dout = 16'hDEAD;
        @(negedge clock);
        chk("post_rst_req", imem_req, 1'b0);
        imem_ack = 1'b0;
        sb.delete();
        exp_addr = RST_PC;
        dead     = 1'b0;
    endtask

    initial begin
        imem_ack  = 1'b0;
        imem_dout = '0;
        br_taken  = 1'b0;
        taddr     = '0;
        dec_ready = 1'b0;
        dead      = 1'b0;
        exp_addr  = RST_PC;

        // Streaming fetch with decode always ready.
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("first_req", imem_req, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t1_pc", pc, 16'h3002);
        repeat (2) cyc(1'b0, 1'b0, 16'h0, 1'b1);

        // Fill to DEPTH with decode stalled, then one pop reopens fetch.
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        acks_taken = 0;
        repeat (8) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t2_acks", acks_taken, 4);
        chk("t2_fill", fill_level, 4);
        chk("t2_req", imem_req, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t2_rereq", imem_req, 1'b1);
        chk("t2_readdr", imem_addr, 16'h3004);
        repeat (5) cyc(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect with a fetch outstanding: late ack is dropped.
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b1, 16'h4000, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_drop_req", imem_req, 1'b1);
        chk("t3_drop_addr", imem_addr, 16'h3002);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_req", imem_req, 1'b1);
        chk("t3_addr", imem_addr, 16'h4000);
        chk("t3_valid", dec_valid, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect and ack in the same cycle with two entries buffered.
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b1, 16'h5000, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t4_fill", fill_level, 0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 16'h5000);

        // PC wrap at FFFF, redirect overriding a pop.
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b1, 16'hFFFF, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_addr", imem_addr, 16'hFFFF);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t5_wrap_addr", imem_addr, 16'h0000);
        chk("t5_npc", dec_npc, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_pc", pc, 16'h0001);
        chk("t5_npc2", dec_npc, 16'h0001);

        // Reset while a request is outstanding with three entries buffered.
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t6_fill", fill_level, 3);
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t6_req", imem_req, 1'b1);
        chk("t6_addr", imem_addr, 16'h3000);
        chk("t6_fill0", fill_level, 0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1);
`ifdef LC3_FETCH_BYPASS_EN
        chk("t6_bypass_valid", dec_valid, 1'b1);
`else
        chk("t6_latency_valid", dec_valid, 1'b0);
`endif
        repeat (4) cyc(1'b0, 1'b0, 16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
